// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_e;

  localparam logic IDLE_LEVEL    = 1'b1;
  localparam int   MAX_DATA_BITS = 9;

  // Narrower words are zero-extended; the extra zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input parity_e mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: valid/ready push, pop strobe, registered occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (level != LVL_W'(DEPTH));
  assign do_push    = push_valid && push_ready;
  // Pop is qualified by the pre-edge level, so a word never falls through.
  assign do_pop     = pop && (level != '0);
  assign pop_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, configurable frame format and break
// generation; paced by an external one-cycle bit-rate tick.
module uart_tx_fifo #(
  parameter int                DATA_BITS  = 8,
  parameter uart_pkg::parity_e PARITY     = uart_pkg::PAR_EVEN,
  parameter int                STOP_BITS  = 1,
  parameter int                FIFO_DEPTH = 4,
  parameter int                BREAK_BITS = 13
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tick,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  input  logic                              break_req,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  import uart_pkg::*;

  localparam int CNT_MAX = (DATA_BITS > BREAK_BITS) ? DATA_BITS : BREAK_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP  = CNT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_BREAK = CNT_W'(BREAK_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  tx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic [DATA_BITS-1:0] head;
  logic                 fifo_nonempty;
  logic                 frame_end;
  logic                 pop;

  assign fifo_nonempty = (fifo_level != '0);
  assign frame_end     = (state == STOP) && (cnt == LAST_STOP);
  // Break outranks queued data, both from IDLE and at the end of a frame.
  assign pop  = tick && fifo_nonempty && !break_req && ((state == IDLE) || frame_end);
  assign busy = (state != IDLE) || fifo_nonempty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_data  (tx_data),
    .push_valid (tx_valid),
    .push_ready (tx_ready),
    .pop        (pop),
    .pop_data   (head),
    .level      (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= head;
      par   <= parity_bit(MAX_DATA_BITS'(head), PARITY);
    end else if (tick && state == DATA) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx    <= IDLE_LEVEL;
      cnt   <= '0;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          if (break_req) begin
            state <= BREAK;
            tx    <= 1'b0;
            cnt   <= '0;
          end else if (fifo_nonempty) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          state <= DATA;
          tx    <= shreg[0];
          cnt   <= '0;
        end
        DATA: begin
          if (cnt == LAST_DATA) begin
            cnt <= '0;
            if (PARITY != PAR_NONE) begin
              state <= uart_pkg::PARITY;
              tx    <= par;
            end else begin
              state <= STOP;
              tx    <= IDLE_LEVEL;
            end
          end else begin
            // shreg shifts on this same edge, so bit 1 is the next bit out.
            cnt <= cnt + CNT_W'(1);
            tx  <= shreg[1];
          end
        end
        uart_pkg::PARITY: begin
          state <= STOP;
          tx    <= IDLE_LEVEL;
          cnt   <= '0;
        end
        STOP: begin
          if (cnt == LAST_STOP) begin
            cnt <= '0;
            if (fifo_nonempty && !break_req) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        BREAK: begin
          if (cnt == LAST_BREAK) begin
            state <= STOP;
            tx    <= IDLE_LEVEL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8E1 transmitter. Supports configurable data width, parity mode, stop bits and break generation. A FIFO with a valid/ready write interface allows back-to-back frames with no idle gap. It sits between the host-side byte producer and the TX pin, and is paced by an external one-clk-wide bit-rate tick.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
PARITY, PAR_EVEN, parity mode from uart_pkg::parity_e: PAR_NONE, PAR_EVEN or PAR_ODD.
STOP_BITS, 1, stop bits per frame; legal 1 or 2.
FIFO_DEPTH, 4, entries; power of two, minimum 2.
BREAK_BITS, 13, tick periods tx is held low for a break.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
tick  in  1  bit-rate strobe, one clk wide; may be high every cycle
tx_data  in  DATA_BITS  word to send
tx_valid  in  1  producer offers tx_data
tx_ready  out  1  FIFO can accept; equals !full
break_req  in  1  level; request a break condition
tx  out  1  serial line; idles high
busy  out  1  high when state != IDLE or FIFO non-empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, busy=0, tx_ready=1, fifo_level=0.
  - FIFO emptied, FSM to IDLE.
  - Mid-frame reset aborts the frame immediately; the line returns high in the same cycle.
- Write: push occurs on the clk edge when tx_valid && tx_ready.
  - tx_valid while full is held off (ready=0); the data is not lost, the producer keeps it.
- FIFO rules:
  - Push and pop in the same cycle: level unchanged.
  - Pop occurs only if the FIFO was non-empty before the edge; there is no fall-through.
  - A word pushed into an empty FIFO can start a frame at the earliest tick one cycle later.
- Frame layout: START(0), DATA LSB first, PARITY (if enabled), STOP_BITS x 1.
  - Frame length = 1 + DATA_BITS + (PARITY!=PAR_NONE) + STOP_BITS tick periods.
- Parity:
  - PAR_EVEN: bit = ^data.
  - PAR_ODD: bit = ~^data.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. All transitions occur only on clk edges with tick=1.
  - IDLE: tx=1.
    - break_req=1: go to BREAK, tx<=0. Break has priority over queued data.
    - Else FIFO non-empty: pop into the shift register, compute parity, go to START, tx<=0.
  - START -> DATA: tx<=data[0], bit counter=0.
  - DATA: shift one bit per tick. After bit DATA_BITS-1 has had one tick period, go to PARITY if enabled, else STOP. tx<=1 on entering STOP.
  - STOP: stays for STOP_BITS tick periods. On its final tick:
    - FIFO non-empty and no break_req: pop and go directly to START, tx<=0. Back-to-back frames have zero idle gap.
    - Otherwise go to IDLE.
  - BREAK: tx=0 for BREAK_BITS tick periods, then tx<=1 and go to STOP.
    - This guarantees at least STOP_BITS high periods (mark) before the next frame.
    - break_req must be held until break start; deassertion mid-break does not shorten it.
- tx is a register output; it changes only on tick edges (or on reset).
- Bit counter width: $clog2(max(DATA_BITS, BREAK_BITS)+1). Counter wrap never occurs within a legal frame.
- busy drops on the same edge that enters IDLE with an empty FIFO.
- Parameter checks: illegal DATA_BITS, STOP_BITS or FIFO_DEPTH give an elaboration-time $error.

Decomposition:
- uart_pkg:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - localparam IDLE_LEVEL=1'b1.
  - Function parity_bit(data, mode).
- Sub-module sync_fifo: parametrised WIDTH/DEPTH, valid/ready push, pop strobe, level output, async active-low reset.
- FSM and shift register stay in uart_tx_fifo.

Test Plan:
- DATA_BITS=8, PAR_EVEN, STOP_BITS=1; push 0xA5 with tick every 4 clk.
  - Required: tx per tick = 0 | 1 0 1 0 0 1 0 1 | 0 | 1, then idle high.
  - busy is high for 11 tick periods.
- PAR_ODD; push 0x01 -> parity bit 0. PAR_EVEN; push 0x01 -> parity bit 1. Frame is otherwise identical.
- FIFO_DEPTH=4; push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back.
  - Required: tx_ready=0 after the 4th push, reasserting on the first pop.
  - 5 frames sent contiguously: 55 tick periods, no high gap between STOP and START.
- DATA_BITS=7, PAR_NONE, STOP_BITS=2; push 0x7F.
  - Required: 10-tick frame, 0 followed by seven 1s and two stop 1s.
- BREAK_BITS=13; break_req=1 while idle with a byte also queued.
  - Required: tx low for exactly 13 ticks, then high for 1 tick (STOP), then the queued byte's START.
- Mid-frame reset: pull rst_n low during the 4th data bit.
  - Required: tx=1, fifo_level=0, busy=0 within the same cycle.
  - After release, the first push transmits a full correct frame.
